// File: rtl/earth_dram_rd_dma.sv
// earth_dram_rd_dma: credit-based DRAM read DMA feeding a valid/ready line stream.
// Optional macro EARTH_RD_PERF_EN adds stall_cnt (RUN cycles where credit blocked a read).
module earth_dram_rd_dma #(
    parameter int DATA_W     = 2048,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              dram_rd_en,
    output logic [ADDR_W-1:0] dram_rd_addr,
    input  logic [DATA_W-1:0] dram_rd_data,
    input  logic              dram_rd_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef EARTH_RD_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q, issued, received;
    logic [CNT_W-1:0]  outstanding, fifo_count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              start_acc, want, credit_ok, issue, ret, pop, done_nx;
    logic [ADDR_W-1:0] cur_base;
    logic [LEN_W-1:0]  cur_len, cur_issued, issued_nx;

    // The first read is issued straight from IDLE on the accepting edge, so the
    // "current" transfer parameters come from cfg_* in that cycle.
    always_comb begin
        start_acc  = (state == S_IDLE) && cfg_start;
        cur_base   = start_acc ? cfg_base : base_q;
        cur_len    = start_acc ? cfg_len : len_q;
        cur_issued = start_acc ? '0 : issued;
        want       = (start_acc || (state == S_RUN)) && (cur_issued < cur_len);
        credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C;
        issue      = want && credit_ok;
        issued_nx  = cur_issued + LEN_W'(issue);
        ret        = dram_rd_valid && (outstanding != '0);
        pop        = out_valid && out_ready;

        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_acc) begin
                    if (cfg_len == '0) done_nx = 1'b1;
                    else state_nx = (issued_nx == cfg_len) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (issued_nx == len_q) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if ((received == len_q) && (fifo_count == '0)) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // outstanding is bumped when the read is decided (one cycle before dram_rd_en
    // is seen), which keeps the credit check exact with back-to-back issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            len_q        <= '0;
            issued       <= '0;
            received     <= '0;
            outstanding  <= '0;
            dram_rd_en   <= 1'b0;
            dram_rd_addr <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
        end else begin
            done <= done_nx;
            if (start_acc) begin
                base_q <= cfg_base;
                len_q  <= cfg_len;
            end
            issued      <= issued_nx;
            received    <= (start_acc ? '0 : received) + LEN_W'(ret);
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(ret);
            dram_rd_en  <= issue;
            if (issue) dram_rd_addr <= cur_base + ADDR_W'(cur_issued);
            if (dram_rd_valid && !ret) err <= 1'b1;
            if (ret) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(ret) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (ret) mem[wr_ptr] <= dram_rd_data;
    end

    assign out_data  = mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign busy      = (state != S_IDLE);

`ifdef EARTH_RD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt <= '0;
        end else if ((state == S_RUN) && (issued < len_q) && !credit_ok && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_earth_dram_rd_dma.sv
// Bench for earth_dram_rd_dma: 1-cycle DRAM model, table of transfers, hand sequences.
// Valid/ready: a line moves when out_valid & out_ready are both high at a rising edge.
module tb_earth_dram_rd_dma;
    localparam int DATA_W = 2048;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base;
    logic [LEN_W-1:0]  cfg_len;
    logic              busy, done, err, dram_rd_en, out_valid, out_ready;
    logic [ADDR_W-1:0] dram_rd_addr;
    logic [DATA_W-1:0] dram_rd_data;
    logic              dram_rd_valid;
    logic [DATA_W-1:0] out_data;
    logic              model_valid = 1'b0;
    logic              stray_inj = 1'b0;
`ifdef EARTH_RD_PERF_EN
    logic [31:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    earth_dram_rd_dma dut (
        .clk(clk),
`ifdef EARTH_RD_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_base(cfg_base),
        .cfg_len(cfg_len),
        .busy(busy),
        .done(done),
        .err(err),
        .dram_rd_en(dram_rd_en),
        .dram_rd_addr(dram_rd_addr),
        .dram_rd_data(dram_rd_data),
        .dram_rd_valid(dram_rd_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, rd_cnt = 0, out_cnt = 0, done_cnt = 0, rd_rise = 0, rd_last = 0;
    logic prev_rd_en = 1'b0;
    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] exp_q[$];

    function automatic logic [DATA_W-1:0] line_of(input logic [31:0] a);
        line_of = {64{a ^ 32'h5A5A_0F0F}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DRAM model: every request returns its line exactly one cycle later.
    always begin
        @(posedge clk);
        #1;
        model_valid  = dram_rd_en;
        dram_rd_data = line_of(dram_rd_addr);
    end
    assign dram_rd_valid = model_valid | stray_inj;

    // Monitors sample mid-cycle: read addresses, delivered lines, done pulses.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        cyc++;
        if (dram_rd_en) begin
            rd_cnt++;
            if (!prev_rd_en) rd_rise = cyc;
            rd_last = cyc;
            if (addr_q.size() > 0) begin
                chk("rd_addr", 64'(dram_rd_addr), 64'(addr_q.pop_front()));
            end else begin
                n_checks++;
                $display("FAIL rd_unexpected: read of %0h, none expected", dram_rd_addr);
            end
        end
        prev_rd_en = dram_rd_en;
        if (out_valid && out_ready) begin
            out_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: got %0h, none expected", out_data[63:0]);
            end else begin
                e = exp_q.pop_front();
                if (out_data === e) n_pass++;
                else $display("FAIL out_data: got %0h expected %0h", out_data[63:0], e[63:0]);
            end
        end
        if (done) done_cnt++;
    end

    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        int          ready_at;    // cycle out_ready rises (0 = from start)
        int          span;        // expected last-first read cycle, -1 skip
        int          chk_cyc;     // cycle to sample read count, -1 skip
        int          rd_at_chk;
        int          restart_at;  // cycle of an ignored second start, -1 none
        int          stall;       // 1: stall_cnt>0 expected, 0: zero
    } vec_t;

    vec_t vecs[6];

    task automatic load_expect(input logic [31:0] base, input int len);
        addr_q.delete();
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(base + 32'(i));
            exp_q.push_back(line_of(base + 32'(i)));
        end
    endtask

    task automatic run_xfer(input vec_t v);
        logic done_seen;
        int rd0, dn0;
        load_expect(v.base, int'(v.len));
        rd0 = rd_cnt;
        dn0 = done_cnt;
        out_ready = (v.ready_at == 0);
        cfg_base  = v.base;
        cfg_len   = v.len;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("first_rd_en", 64'(dram_rd_en), 64'(1));
        chk("busy_on_start", 64'(busy), 64'(1));
        done_seen = 1'b0;
        for (int c = 2; c <= 300 && !done_seen; c++) begin
            step();
            if (c == v.chk_cyc) chk("rd_cnt_stalled", 64'(rd_cnt - rd0), 64'(v.rd_at_chk));
            if (c == v.ready_at) out_ready = 1'b1;
            if (c == v.restart_at) begin
                cfg_base  = v.base ^ 32'h0000_0700;
                cfg_len   = v.len + 16'd3;
                cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            if (done) done_seen = 1'b1;
        end
        cfg_start = 1'b0;
        chk("done_seen", 64'(done_seen), 64'(1));
        step();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("busy_after", 64'(busy), 64'(0));
        repeat (3) step();
        chk("done_cnt", 64'(done_cnt - dn0), 64'(1));
        chk("rd_cnt", 64'(rd_cnt - rd0), 64'(v.len));
        chk("lines_left", 64'(exp_q.size()), 64'(0));
        chk("addr_left", 64'(addr_q.size()), 64'(0));
        if (v.span >= 0) chk("rd_span", 64'(rd_last - rd_rise), 64'(v.span));
`ifdef EARTH_RD_PERF_EN
        if (v.stall != 0) chk("stall_pos", 64'(stall_cnt != 0), 64'(1));
        else chk("stall_zero", 64'(stall_cnt), 64'(0));
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_rd_en"}, 64'(dram_rd_en), 64'(0));
        chk({tag, "_rd_addr"}, 64'(dram_rd_addr), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, dn0;
        vec_t v6;
        vecs[0] = '{32'h0000_0000, 16'd4, 0, 3, -1, 0, -1, 0};
        vecs[1] = '{32'h0000_0100, 16'd10, 20, -1, 20, 4, -1, 1};
        vecs[2] = '{32'hFFFF_FFFE, 16'd4, 0, 3, -1, 0, -1, 0};
        vecs[3] = '{32'h0000_0200, 16'd8, 0, 7, -1, 0, 3, 0};
        vecs[4] = '{32'h1234_5678, 16'd1, 0, 0, -1, 0, -1, 0};
        vecs[5] = '{32'h8000_0000, 16'd7, 5, -1, -1, 0, -1, 1};

        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_base = '0;
        cfg_len = '0;
        out_ready = 1'b0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_xfer(vecs[i]);

        // Zero-length transfer: immediate done, never busy, no reads.
        rd0 = rd_cnt;
        dn0 = done_cnt;
        addr_q.delete();
        cfg_base = 32'h77;
        cfg_len = '0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("len0_done", 64'(done), 64'(1));
        chk("len0_busy", 64'(busy), 64'(0));
        chk("len0_rd_en", 64'(dram_rd_en), 64'(0));
        step();
        chk("len0_done_off", 64'(done), 64'(0));
        repeat (3) step();
        chk("len0_no_rd", 64'(rd_cnt - rd0), 64'(0));
        chk("len0_done_cnt", 64'(done_cnt - dn0), 64'(1));

        // Reset after the third delivered line, then a clean short transfer.
        load_expect(32'h40, 8);
        dn0 = done_cnt;
        rd0 = out_cnt;
        out_ready = 1'b1;
        cfg_base = 32'h40;
        cfg_len = 16'd8;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int c = 0; c < 100 && (out_cnt - rd0) < 3; c++) step();
        chk("midrst_reached", 64'((out_cnt - rd0) >= 3), 64'(1));
        rst = 1'b1;
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        addr_q.delete();
        exp_q.delete();
        repeat (2) step();
        chk("midrst_no_done", 64'(done_cnt - dn0), 64'(0));
        chk("midrst_err", 64'(err), 64'(0));
        v6 = '{32'h0000_0050, 16'd2, 0, 1, -1, 0, -1, 0};
        run_xfer(v6);
        chk("after_rst_err", 64'(err), 64'(0));

        // Stray return while idle: dropped, err sticks until reset.
        stray_inj = 1'b1;
        step();
        stray_inj = 1'b0;
        chk("stray_err", 64'(err), 64'(1));
        chk("stray_dropped", 64'(out_valid), 64'(0));
        repeat (2) step();
        chk("stray_err_sticky", 64'(err), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stray_err_cleared", 64'(err), 64'(0));
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
